// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver/transmitter pair.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity mode encodings
//   uart_state_e              : receiver FSM state encoding
//   majority3                 : 2-of-3 vote used for bit sampling
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } uart_state_e;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick generator.
//   clk   : system clock
//   reset : synchronous, active-high
//   tick  : one-clk pulse every CLK_DIV clocks (at the counter's terminal count)
module uart_tick_gen #(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LastCnt);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote sampling,
// start-glitch rejection, parity/framing/overrun flags and valid/ready output.
//   clk, reset             : system clock, synchronous active-high reset
//   rx_in                  : asynchronous serial line, idle high
//   rx_data/rx_valid       : received word, held until rx_ready accepts it
//   rx_ready               : consumer accept
//   parity_err, frame_err  : qualifiers of the held word
//   overrun                : 1-clk pulse when a completed frame is dropped
//   busy                   : receiver FSM not idle
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 5,
    parameter int unsigned OVS       = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 2,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(OVS);
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] SampleCnt = CntW'(OVS / 2);
    localparam logic [CntW-1:0] LastCnt   = CntW'(OVS - 1);
    localparam logic [BitW-1:0] LastBit   = BitW'(DATA_BITS - 1);
    localparam logic            LastStop  = (STOP_BITS > 1) ? 1'b1 : 1'b0;

    logic tick;

    uart_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Synchroniser and vote history; both idle at 1 so reset never looks like a start bit.
    logic [1:0] sync_q;
    logic [2:0] samp_q;
    logic       rx_sync;
    logic       bit_now;

    assign rx_sync = sync_q[1];
    assign bit_now = majority3(samp_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            samp_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rx_in};
            if (tick) begin
                samp_q <= {samp_q[1:0], rx_sync};
            end
        end
    end

    uart_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 complete;
    logic                 at_sample, at_end, par_exp;

    assign at_sample = (cnt_q == SampleCnt);
    assign at_end    = (cnt_q == LastCnt);
    assign par_exp   = (PARITY == PAR_EVEN) ? ^data_q : ~^data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        complete   = 1'b0;
        if (tick) begin
            if (state_q != StIdle && state_q != StBrkWait) begin
                cnt_d = at_end ? '0 : cnt_q + CntW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (!rx_sync) begin
                        state_d    = StStart;
                        cnt_d      = '0;
                        bit_idx_d  = '0;
                        stop_idx_d = 1'b0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                    end
                end
                StStart: begin
                    if (at_sample && bit_now) begin
                        state_d = StIdle;
                    end else if (at_end) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (at_sample) begin
                        data_d = {bit_now, data_q[DATA_BITS-1:1]};
                    end
                    if (at_end) begin
                        bit_idx_d = bit_idx_q + BitW'(1);
                        if (bit_idx_q == LastBit) begin
                            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                        end
                    end
                end
                StParity: begin
                    if (at_sample) begin
                        perr_d = (bit_now != par_exp);
                    end
                    if (at_end) begin
                        state_d = StStop;
                    end
                end
                StStop: begin
                    // The last stop bit completes the frame at its centre so a
                    // back-to-back start edge is never missed.
                    if (at_sample) begin
                        ferr_d = ferr_q | ~bit_now;
                        if (stop_idx_q == LastStop) begin
                            complete = 1'b1;
                            state_d  = ferr_d ? StBrkWait : StIdle;
                        end
                    end
                    if (at_end) begin
                        stop_idx_d = 1'b1;
                    end
                end
                StBrkWait: begin
                    if (rx_sync) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Output holding register; independent of the FSM so reception continues while held.
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, parity_err_q, frame_err_q, overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (complete) begin
                if (!rx_valid_q || rx_ready) begin
                    rx_data_q    <= data_q;
                    parity_err_q <= perr_q;
                    frame_err_q  <= ferr_d;
                    rx_valid_q   <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q   <= 1'b0;
                parity_err_q <= 1'b0;
                frame_err_q  <= 1'b0;
            end
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: a default instance (8 data, odd parity,
// 1 stop) and a 7-data, no-parity, 2-stop instance, driven by directed and random frames.
module tb_uart_rx_param;

    localparam int ClkDiv = 5;
    localparam int Ovs    = 8;
    localparam int Bit    = ClkDiv * Ovs;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic       rx_a    = 1'b1;
    logic       ready_a = 1'b1;
    logic [7:0] data_a;
    logic       valid_a, perr_a, ferr_a, ovr_a, busy_a;

    logic       rx_b    = 1'b1;
    logic       ready_b = 1'b1;
    logic [6:0] data_b;
    logic       valid_b, perr_b, ferr_b, ovr_b, busy_b;

    int n_vec = 0;
    int n_bad = 0;
    int ovr_cnt_a = 0;
    logic [9:0] got_a[$];
    logic [8:0] got_b[$];
    int rd_a = 0;
    int rd_b = 0;

    uart_rx_param #(
        .CLK_DIV(ClkDiv), .OVS(Ovs), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .rx_in(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a), .overrun(ovr_a),
        .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_DIV(ClkDiv), .OVS(Ovs), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .reset(reset), .rx_in(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b), .overrun(ovr_b),
        .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Consumer-side monitor: every accepted word, plus overrun pulse count.
    always @(negedge clk) begin
        if (valid_a && ready_a) got_a.push_back({ferr_a, perr_a, data_a});
        if (valid_b && ready_b) got_b.push_back({ferr_b, perr_b, data_b});
        if (ovr_a) ovr_cnt_a++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic [9:0] model_a(input logic [7:0] d, input logic pbit, input logic sbit);
        logic perr;
        perr = (($countones({d, pbit}) % 2) == 0);
        return {~sbit, perr, d};
    endfunction

    function automatic logic odd_pbit(input logic [7:0] d);
        return (($countones(d) % 2) == 0);
    endfunction

    function automatic logic [8:0] model_b(input logic [6:0] d, input logic s1, input logic s2);
        return {~(s1 & s2), 1'b0, d};
    endfunction

    task automatic send_a(input logic [7:0] d, input logic pbit, input logic sbit,
                          input int gbit, output int vclk);
        logic [10:0] fr;
        fr   = {sbit, pbit, d, 1'b0};
        vclk = -1;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < Bit; c++) begin
                rx_a = (i == gbit && c >= Bit / 2 - 5 && c < Bit / 2) ? 1'b0 : fr[i];
                @(negedge clk);
                if (i == 10 && vclk < 0 && valid_a) vclk = c;
            end
        end
    endtask

    task automatic send_b(input logic [6:0] d, input logic s1, input logic s2);
        logic [9:0] fr;
        fr = {s2, s1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_b = fr[i];
            repeat (Bit) @(negedge clk);
        end
    endtask

    task automatic idle_a(input int bits);
        rx_a = 1'b1;
        repeat (bits * Bit) @(negedge clk);
    endtask

    task automatic idle_b(input int bits);
        rx_b = 1'b1;
        repeat (bits * Bit) @(negedge clk);
    endtask

    task automatic expect_a(input string tag, input logic [9:0] exp);
        check_value({tag, "_count"}, 32'(got_a.size() - rd_a), 32'd1);
        if (got_a.size() > rd_a) check_value(tag, 32'(got_a[rd_a]), 32'(exp));
        rd_a = got_a.size();
    endtask

    task automatic expect_b(input string tag, input logic [8:0] exp);
        check_value({tag, "_count"}, 32'(got_b.size() - rd_b), 32'd1);
        if (got_b.size() > rd_b) check_value(tag, 32'(got_b[rd_b]), 32'(exp));
        rd_b = got_b.size();
    endtask

    initial begin
        int         vclk;
        int         o0;
        logic       busy_all;
        logic [7:0] d;
        logic [6:0] d7;
        logic       pb, sb, s1, s2;
        int         gb;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_valid", 32'(valid_a), 32'd0);
        check_value("rst_data", 32'(data_a), 32'd0);
        check_value("rst_perr", 32'(perr_a), 32'd0);
        check_value("rst_ferr", 32'(ferr_a), 32'd0);
        check_value("rst_ovr", 32'(ovr_a), 32'd0);
        check_value("rst_busy", 32'(busy_a), 32'd0);
        check_value("rst_b_valid", 32'(valid_b), 32'd0);
        check_value("rst_b_busy", 32'(busy_b), 32'd0);

        // 0xA5 with correct odd parity; word must appear near the stop-bit centre.
        send_a(8'hA5, 1'b1, 1'b1, -1, vclk);
        check_value("a5_timing", 32'(vclk >= Bit / 2 && vclk <= Bit / 2 + 12), 32'd1);
        idle_a(2);
        expect_a("a5_good", model_a(8'hA5, 1'b1, 1'b1));

        send_a(8'hA5, 1'b0, 1'b1, -1, vclk);
        idle_a(2);
        expect_a("a5_badpar", model_a(8'hA5, 1'b0, 1'b1));

        // Break: stop bit low, line held low 20 bits -> exactly one framing-error word.
        send_a(8'h3C, odd_pbit(8'h3C), 1'b0, -1, vclk);
        rx_a = 1'b0;
        busy_all = 1'b1;
        repeat (20 * Bit) begin
            @(negedge clk);
            busy_all &= busy_a;
        end
        check_value("brk_busy", 32'(busy_all), 32'd1);
        expect_a("brk_word", model_a(8'h3C, odd_pbit(8'h3C), 1'b0));
        idle_a(3);
        check_value("brk_idle", 32'(busy_a), 32'd0);
        check_value("brk_single", 32'(got_a.size() - rd_a), 32'd0);
        send_a(8'h55, odd_pbit(8'h55), 1'b1, -1, vclk);
        idle_a(2);
        expect_a("after_brk", model_a(8'h55, odd_pbit(8'h55), 1'b1));

        // Short start glitch is rejected.
        rx_a = 1'b0;
        repeat (8) @(negedge clk);
        idle_a(3);
        check_value("stglitch_busy", 32'(busy_a), 32'd0);
        check_value("stglitch_none", 32'(got_a.size() - rd_a), 32'd0);

        // 5-clk low glitch inside data bit 3 of 0xFF is outvoted.
        send_a(8'hFF, odd_pbit(8'hFF), 1'b1, 4, vclk);
        idle_a(2);
        expect_a("glitch_ff", model_a(8'hFF, odd_pbit(8'hFF), 1'b1));

        // Overrun: second word dropped while the first is held.
        ready_a = 1'b0;
        o0 = ovr_cnt_a;
        send_a(8'h11, odd_pbit(8'h11), 1'b1, -1, vclk);
        idle_a(1);
        check_value("ovr_hold_valid", 32'(valid_a), 32'd1);
        check_value("ovr_hold_data", 32'(data_a), 32'h11);
        send_a(8'h22, odd_pbit(8'h22), 1'b1, -1, vclk);
        idle_a(1);
        check_value("ovr_keep_data", 32'(data_a), 32'h11);
        check_value("ovr_pulses", 32'(ovr_cnt_a - o0), 32'd1);
        @(posedge clk);
        #1 ready_a = 1'b1;
        @(negedge clk);
        check_value("ovr_accept_valid", 32'(valid_a), 32'd1);
        @(negedge clk);
        check_value("ovr_drop_valid", 32'(valid_a), 32'd0);
        expect_a("ovr_word", model_a(8'h11, odd_pbit(8'h11), 1'b1));

        // Random frames: occasional parity/stop errors and data-bit glitches.
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom);
            pb = odd_pbit(d) ^ ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 4) != 0);
            gb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : -1;
            send_a(d, pb, sb, gb, vclk);
            idle_a(int'($urandom_range(1, 3)));
            expect_a("rand_a", model_a(d, pb, sb));
        end

        // 7-bit, no parity, 2 stop bits.
        ready_b = 1'b0;
        send_b(7'h5A, 1'b1, 1'b1);
        idle_b(1);
        check_value("b_5a_valid", 32'(valid_b), 32'd1);
        check_value("b_5a_data", 32'(data_b), 32'h5A);
        check_value("b_5a_perr", 32'(perr_b), 32'd0);
        check_value("b_5a_ferr", 32'(ferr_b), 32'd0);

        // Reset in the middle of data bit 3 of the next frame.
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < ((i == 4) ? Bit / 2 : Bit); c++) begin
                rx_b = (i == 0) ? 1'b0 : d7_bit(7'h3C, i - 1);
                @(negedge clk);
            end
        end
        reset = 1'b1;
        rx_b  = 1'b1;
        @(negedge clk);
        check_value("b_rst_valid", 32'(valid_b), 32'd0);
        check_value("b_rst_data", 32'(data_b), 32'd0);
        check_value("b_rst_flags", 32'({perr_b, ferr_b, ovr_b}), 32'd0);
        check_value("b_rst_busy", 32'(busy_b), 32'd0);
        reset = 1'b0;
        idle_b(2);
        check_value("b_rst_quiet", 32'(busy_b | valid_b), 32'd0);
        ready_b = 1'b1;
        send_b(7'h3C, 1'b1, 1'b1);
        idle_b(2);
        expect_b("b_3c", model_b(7'h3C, 1'b1, 1'b1));

        for (int n = 0; n < 6; n++) begin
            d7 = 7'($urandom);
            s1 = ($urandom_range(0, 3) != 0);
            s2 = ($urandom_range(0, 3) != 0);
            send_b(d7, s1, s2);
            idle_b(int'($urandom_range(1, 3)));
            expect_b("rand_b", model_b(d7, s1, s2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    function automatic logic d7_bit(input logic [6:0] d, input int idx);
        return d[idx];
    endfunction

endmodule
